// File: rtl/spi_slave_core.sv
// rtl/spi_slave_core.sv - SPI responder engine with oversampled sclk/ss_n/mosi, all CPOL/CPHA modes, LSB first
// Optional feature macro: SPI_SLAVE_TX_UNDERRUN_EN (adds o_tx_underrun pulse output)
module spi_slave_core #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_arst,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_busy,
  input  logic              i_sclk,
  input  logic              i_ss_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_miso_oe
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
  ,
  output logic              o_tx_underrun
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ssn_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_q;
  logic                   r_ssn_q;

  state_t                 r_state;
  logic [DATA_W-1:0]      r_tx_buf;
  logic                   r_buf_full;
  logic [DATA_W-1:0]      r_tx_shift;
  logic [DATA_W-2:0]      r_rx_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_shift_pend;
  logic                   r_word_done;
  logic [DATA_W-1:0]      r_rx_data;
  logic                   r_rx_valid;
  logic                   r_busy;
  logic                   r_miso_oe;
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
  logic                   r_tx_underrun;
`endif

  logic w_sclk_s, w_ssn_s, w_mosi_s;
  logic w_sclk_rise, w_sclk_fall, w_lead, w_trail, w_sample, w_drive;
  logic w_ss_fall, w_ss_rise;
  logic w_load, w_start, w_reload, w_consume;
  logic [DATA_W-1:0] w_fill_word;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_ssn_s  = r_ssn_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  assign w_sclk_rise = w_sclk_s & ~r_sclk_q;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_q;
  // Leading edge leaves the idle level, trailing edge returns to it
  assign w_lead   = i_cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail  = i_cpol ? w_sclk_rise : w_sclk_fall;
  assign w_sample = i_cpha ? w_trail : w_lead;
  assign w_drive  = i_cpha ? w_lead : w_trail;

  assign w_ss_fall = ~w_ssn_s & r_ssn_q;
  assign w_ss_rise = w_ssn_s & ~r_ssn_q;

  // A word load happens at frame start or at the drive edge after a completed word
  assign w_load    = i_tx_valid & ~r_buf_full;
  assign w_start   = (r_state == ST_IDLE) & w_ss_fall;
  assign w_reload  = (r_state == ST_SHIFT) & ~w_ss_rise & w_drive & r_shift_pend & r_word_done;
  assign w_consume = w_start | w_reload;
  // Empty buffer at a word load sends all-ones
  assign w_fill_word = r_buf_full ? r_tx_buf : {DATA_W{1'b1}};

  assign o_tx_ready = ~r_buf_full;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_busy     = r_busy;
  assign o_miso_oe  = r_miso_oe;
  assign o_miso     = r_miso_oe & r_tx_shift[0];
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
  assign o_tx_underrun = r_tx_underrun;
`endif

  // Synchronise the external bus pins and keep the previous values for edge detection
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_sclk_sync <= '0;
      r_ssn_sync  <= '1;
      r_mosi_sync <= '0;
      r_sclk_q    <= 1'b0;
      r_ssn_q     <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_ssn_sync  <= {r_ssn_sync[SYNC_STAGES-2:0], i_ss_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sclk_q    <= w_sclk_s;
      r_ssn_q     <= w_ssn_s;
    end
  end

  // Tx holding buffer: a consume empties it unless a new word is accepted in the same cycle
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_tx_buf   <= '0;
      r_buf_full <= 1'b0;
    end else begin
      if (w_load) begin
        r_tx_buf   <= i_tx_data;
        r_buf_full <= 1'b1;
      end else if (w_consume) begin
        r_buf_full <= 1'b0;
      end
    end
  end

  // Frame FSM: shifts rx on sample edges, tx on drive edges, reloads tx between words
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_state      <= ST_IDLE;
      r_tx_shift   <= '0;
      r_rx_shift   <= '0;
      r_bit_cnt    <= '0;
      r_shift_pend <= 1'b0;
      r_word_done  <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_miso_oe    <= 1'b0;
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
      r_tx_underrun <= 1'b0;
`endif
    end else begin
      r_rx_valid <= 1'b0;
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
      r_tx_underrun <= w_consume & ~r_buf_full;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_ss_fall) begin
            r_tx_shift   <= w_fill_word;
            r_bit_cnt    <= '0;
            r_shift_pend <= 1'b0;
            r_word_done  <= 1'b0;
            r_busy       <= 1'b1;
            r_miso_oe    <= 1'b1;
            r_state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_ss_rise) begin
            // Deselect wins over any edge seen in the same cycle; partial word is dropped
            r_busy    <= 1'b0;
            r_miso_oe <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            if (w_sample) begin
              r_rx_shift   <= {w_mosi_s, r_rx_shift[DATA_W-2:1]};
              r_shift_pend <= 1'b1;
              if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                r_bit_cnt   <= '0;
                r_rx_data   <= {w_mosi_s, r_rx_shift};
                r_rx_valid  <= 1'b1;
                r_word_done <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
            if (w_drive && r_shift_pend) begin
              r_shift_pend <= 1'b0;
              if (r_word_done) begin
                r_tx_shift  <= w_fill_word;
                r_word_done <= 1'b0;
              end else begin
                r_tx_shift <= {1'b0, r_tx_shift[DATA_W-1:1]};
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_core.sv
// tb/tb_spi_slave_core.sv - directed scoreboard bench for spi_slave_core acting as bus master
module tb_spi_slave_core;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sclk = 1'b0;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
  logic       tx_underrun;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];
  logic [7:0] rx_log [0:63];
  int         rx_cnt = 0;
  int         rd_idx = 0;
  int         und_cnt = 0;

  spi_slave_core #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .i_clk      (clk),
    .i_arst     (arst),
    .i_cpol     (cpol),
    .i_cpha     (cpha),
    .i_tx_data  (tx_data),
    .i_tx_valid (tx_valid),
    .o_tx_ready (tx_ready),
    .o_rx_data  (rx_data),
    .o_rx_valid (rx_valid),
    .o_busy     (busy),
    .i_sclk     (sclk),
    .i_ss_n     (ss_n),
    .i_mosi     (mosi),
    .o_miso     (miso),
    .o_miso_oe  (miso_oe)
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
    ,
    .o_tx_underrun (tx_underrun)
`endif
  );

  always #5 clk = ~clk;

  // Record every rx_valid pulse with the word it presents
  always @(negedge clk) begin
    if (rx_valid && rx_cnt < 64) begin
      rx_log[rx_cnt] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
  end

`ifdef SPI_SLAVE_TX_UNDERRUN_EN
  // Count underrun pulses
  always @(negedge clk) begin
    if (tx_underrun) und_cnt <= und_cnt + 1;
  end
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    wclk(1);
    tx_valid = 1'b0;
    tx_exp.push_back(d);
  endtask

  task automatic ss_low();
    ss_n = 1'b0;
    wclk(HALF);
  endtask

  task automatic ss_high();
    wclk(HALF);
    ss_n = 1'b1;
    wclk(8);
  endtask

  task automatic xfer(input logic [7:0] w, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = w[i];
        wclk(HALF);
        sclk = ~cpol;
        r[i] = miso;
        wclk(HALF);
        sclk = cpol;
      end else begin
        wclk(HALF);
        sclk = ~cpol;
        mosi = w[i];
        wclk(HALF);
        sclk = cpol;
        r[i] = miso;
      end
    end
  endtask

  task automatic check_rx(input string tag);
    logic [7:0] exp;
    exp = rx_exp.pop_front();
    for (int k = 0; k < 100 && rx_cnt <= rd_idx; k++) wclk(1);
    chk({tag, "_arrived"}, 32'(rx_cnt > rd_idx), 32'd1);
    if (rx_cnt > rd_idx) begin
      chk(tag, rx_log[rd_idx], exp);
      rd_idx++;
    end
  endtask

  initial begin
    logic [7:0] got;
    int und0;

    // Reset state
    wclk(4);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_miso", miso, 0);
    chk("rst_miso_oe", miso_oe, 0);
    arst = 1'b0;
    wclk(6);

    // Mode 0: preload 0xA5, master sends 0x3C
    cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
    load(8'hA5);
    chk("m0_buf_full", tx_ready, 0);
    ss_low();
    chk("m0_busy", busy, 1);
    chk("m0_oe", miso_oe, 1);
    chk("m0_buf_cleared", tx_ready, 1);
    xfer(8'h3C, 8, got);
    rx_exp.push_back(8'h3C);
    chk("m0_miso_word", got, tx_exp.pop_front());
    ss_high();
    chk("m0_oe_off", miso_oe, 0);
    chk("m0_busy_off", busy, 0);
    check_rx("m0_rx");
    chk("m0_single_pulse", rx_cnt, rd_idx);

    // Mode 3: preload 0x81, master sends 0x7E
    cpol = 1'b1; cpha = 1'b1; sclk = 1'b1;
    wclk(8);
    load(8'h81);
    ss_low();
    xfer(8'h7E, 8, got);
    rx_exp.push_back(8'h7E);
    chk("m3_miso_word", got, tx_exp.pop_front());
    ss_high();
    check_rx("m3_rx");
    chk("m3_single_pulse", rx_cnt, rd_idx);

    // Mode 0 back-to-back: 0x11 preloaded, 0x22 loaded mid-frame
    cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
    wclk(8);
    load(8'h11);
    ss_low();
    load(8'h22);
    xfer(8'hF0, 8, got);
    rx_exp.push_back(8'hF0);
    chk("b2b_miso_w1", got, tx_exp.pop_front());
    xfer(8'h0F, 8, got);
    rx_exp.push_back(8'h0F);
    chk("b2b_miso_w2", got, tx_exp.pop_front());
    ss_high();
    check_rx("b2b_rx1");
    check_rx("b2b_rx2");
    chk("b2b_pulse_count", rx_cnt, rd_idx);

    // Mode 1 with no preload: all-ones fill
    cpol = 1'b0; cpha = 1'b1; sclk = 1'b0;
    wclk(8);
    und0 = und_cnt;
    chk("m1_buf_empty", tx_ready, 1);
    ss_low();
    xfer(8'h99, 8, got);
    rx_exp.push_back(8'h99);
    chk("m1_miso_fill", got, 8'hFF);
    ss_high();
    check_rx("m1_rx");
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
    chk("m1_underrun_once", und_cnt - und0, 1);
`endif

    // Abort after 5 bits in mode 0, then full frame 0x5A
    cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
    wclk(8);
    ss_low();
    xfer(8'hE7, 5, got);
    ss_high();
    wclk(20);
    chk("abort_no_rx", rx_cnt, rd_idx);
    chk("abort_rx_kept", rx_data, 8'h99);
    chk("abort_idle_oe", miso_oe, 0);
    ss_low();
    xfer(8'h5A, 8, got);
    rx_exp.push_back(8'h5A);
    chk("abort_next_miso", got, 8'hFF);
    ss_high();
    check_rx("abort_next_rx");

    // arst mid-frame after 3 bits, then frame 0xC3 with tx 0x3C
    ss_low();
    xfer(8'hFF, 3, got);
    arst = 1'b1;
    wclk(2);
    chk("arst_tx_ready", tx_ready, 1);
    chk("arst_rx_data", rx_data, 0);
    chk("arst_rx_valid", rx_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_miso", miso, 0);
    chk("arst_miso_oe", miso_oe, 0);
    ss_n = 1'b1;
    sclk = cpol;
    wclk(4);
    arst = 1'b0;
    wclk(8);
    chk("arst_no_spurious", busy, 0);
    load(8'h3C);
    ss_low();
    xfer(8'hC3, 8, got);
    rx_exp.push_back(8'hC3);
    chk("arst_next_miso", got, tx_exp.pop_front());
    ss_high();
    check_rx("arst_next_rx");
    chk("final_pulse_count", rx_cnt, rd_idx);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
